// File: rtl/booth_radix4_seq.sv
// ---------------------------------------------------------------------------
// booth_radix4_seq
//
// Sequential radix-4 (modified Booth) multiplier. It retires two multiplier
// bits per clock. The operands and the signed/unsigned mode are captured with
// start. The product is written to a holding register, and done pulses for
// one cycle when the product is written.
//
// Parameters
//   M_BITS       multiplicand width (>= 2)
//   N_BITS       multiplier width   (>= 2)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request, accepted only while busy=0
//   signed_mode  1: both operands two's complement, 0: both unsigned
//   mpd          multiplicand [M_BITS-1:0]
//   mpr          multiplier   [N_BITS-1:0]
//   answer       product register [M_BITS+N_BITS-1:0], held between results
//   busy         operation in progress
//   done         one-cycle strobe, answer updated on the same edge
// ---------------------------------------------------------------------------
module booth_radix4_seq #(
    parameter int M_BITS = 12,
    parameter int N_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     signed_mode,
    input  logic [M_BITS-1:0]        mpd,
    input  logic [N_BITS-1:0]        mpr,
    output logic [M_BITS+N_BITS-1:0] answer,
    output logic                     busy,
    output logic                     done
);

    // The multiplier is widened to an even width with at least one guard bit.
    // An unsigned operand then never produces a negative top triplet.
    localparam int NI = 2 * ((N_BITS + 2) / 2);
    localparam int IT = NI / 2;
    localparam int CW = $clog2(IT + 1);
    localparam int MW = M_BITS + 2;
    localparam int AW = M_BITS + 3;
    localparam int PW = M_BITS + N_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 last;

    logic signed [MW-1:0] mcand;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] acc_nxt;
    logic [NI-1:0]        q;
    logic [NI-1:0]        q_nxt;
    logic                 qm1;

    // Booth recoding of one triplet {q[2i+1], q[2i], q[2i-1]} into a partial
    // product in {-2M, -M, 0, +M, +2M}.
    function automatic logic signed [AW-1:0] booth_pp(
        input logic [2:0]           trip,
        input logic signed [MW-1:0] m
    );
        logic signed [AW-1:0] m1;
        logic signed [AW-1:0] pp;
        m1 = {m[MW-1], m};
        pp = '0;
        case (trip)
            3'b001, 3'b010: pp = m1;
            3'b011:         pp = m1 <<< 1;
            3'b100:         pp = -(m1 <<< 1);
            3'b101, 3'b110: pp = -m1;
            default:        pp = '0;
        endcase
        return pp;
    endfunction

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == CW'(1));
    assign busy   = (state == RUN);

    // One iteration: add the partial product to the upper half, then shift
    // {acc, q, qm1} arithmetically right by two. The sign fill comes from the
    // accumulator MSB.
    always_comb begin
        sum     = acc + booth_pp({q[1:0], qm1}, mcand);
        acc_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_nxt   = {sum[1:0], q[NI-1:2]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (cnt == CW'(1)) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            answer <= '0;
        end else begin
            state <= state_nxt;
            done  <= last;
            if (accept) begin
                cnt <= CW'(IT);
            end else if (busy) begin
                cnt <= cnt - CW'(1);
            end
            // After the last shift, {acc, q} holds the full product. Its low
            // PW bits are exact in both modes.
            if (last) begin
                answer <= PW'({acc_nxt, q_nxt});
            end
        end
    end

    // The datapath registers need no reset. They are always loaded on accept
    // before anything reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            mcand <= {{2{signed_mode & mpd[M_BITS-1]}}, mpd};
            acc   <= '0;
            q     <= {{(NI - N_BITS){signed_mode & mpr[N_BITS-1]}}, mpr};
            qm1   <= 1'b0;
        end else if (busy) begin
            acc   <= acc_nxt;
            q     <= q_nxt;
            qm1   <= q[1];
        end
    end

endmodule

// File: tb/tb_booth_radix4_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_radix4_seq
//
// Self-checking bench for booth_radix4_seq. It uses two instances:
//   dut    default parameters (12x8, five cycles per operation)
//   dut2   16x7 (four cycles per operation), used in the random sweep
// Expected products come from plain integer multiplication of the operand
// values, read as signed or unsigned numbers.
// ---------------------------------------------------------------------------
module tb_booth_radix4_seq;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic        sm;
    logic [11:0] mpd;
    logic [7:0]  mpr;
    logic [19:0] answer;
    logic        busy;
    logic        done;

    logic        start2;
    logic        sm2;
    logic [15:0] mpd2;
    logic [6:0]  mpr2;
    logic [22:0] answer2;
    logic        busy2;
    logic        done2;

    int          n_cmp;
    int          n_err;
    logic [19:0] last_exp;

    booth_radix4_seq #(.M_BITS(12), .N_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
        .mpd(mpd), .mpr(mpr), .answer(answer), .busy(busy), .done(done)
    );

    booth_radix4_seq #(.M_BITS(16), .N_BITS(7)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(sm2),
        .mpd(mpd2), .mpr(mpr2), .answer(answer2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference products, computed from operand values.
    function automatic logic [19:0] ref1(input bit s, input logic [11:0] a, input logic [7:0] b);
        longint      pa;
        longint      pb;
        logic [63:0] p;
        pa = longint'(a);
        pb = longint'(b);
        if (s && a[11]) pa = pa - 4096;
        if (s && b[7])  pb = pb - 256;
        p = pa * pb;
        return p[19:0];
    endfunction

    function automatic logic [22:0] ref2(input bit s, input logic [15:0] a, input logic [6:0] b);
        longint      pa;
        longint      pb;
        logic [63:0] p;
        pa = longint'(a);
        pb = longint'(b);
        if (s && a[15]) pa = pa - 65536;
        if (s && b[6])  pb = pb - 128;
        p = pa * pb;
        return p[22:0];
    endfunction

    // Random operand that is biased towards zero, all-ones, min and max.
    function automatic logic [15:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = (32'h1 << w) - 1;
            2:       v = 32'h1 << (w - 1);
            3:       v = (32'h1 << (w - 1)) - 1;
            default: v = $urandom;
        endcase
        v = v & ((32'h1 << w) - 1);
        return v[15:0];
    endfunction

    // Drives one operation on dut and waits (bounded) for its done pulse.
    task automatic run_op(input bit s, input logic [11:0] a, input logic [7:0] b,
                          output logic [19:0] ans, output int lat,
                          output bit busy_ok, output bit done_after);
        sm = s; mpd = a; mpr = b; start = 1'b1;
        tick();
        start = 1'b0;
        busy_ok = busy;
        lat = 0;
        ans = 'x;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (done) begin
                lat = c;
                ans = answer;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        tick();
        done_after = done;
    endtask

    task automatic test_reset();
        logic [19:0] ans;
        int          lat;
        bit          bok;
        bit          dn;
        rst_n = 1'b0;
        start = 0; sm = 0; mpd = 0; mpr = 0;
        start2 = 0; sm2 = 0; mpd2 = 0; mpr2 = 0;
        tick();
        tick();
        n_cmp++; if (answer !== 20'h0) begin n_err++; $display("FAIL reset_answer got %h want 00000", answer); end
        n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if ({answer2, busy2, done2} !== 25'h0) begin n_err++; $display("FAIL reset_dut2 got %h want 0", {answer2, busy2, done2}); end
        // The first start after release is taken at the first edge.
        rst_n = 1'b1;
        run_op(1'b0, 12'h100, 8'h10, ans, lat, bok, dn);
        n_cmp++; if (ans !== 20'h01000) begin n_err++; $display("FAIL first_after_reset got %h want 01000", ans); end
        n_cmp++; if (lat != 5) begin n_err++; $display("FAIL first_after_reset_latency got %0d want 5", lat); end
        n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL first_after_reset_busy got %b want 1", bok); end
        n_cmp++; if (dn !== 1'b0) begin n_err++; $display("FAIL first_after_reset_done_width got %b want 0", dn); end
        last_exp = 20'h01000;
    endtask

    task automatic test_directed();
        bit          ts[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [11:0] ta[5] = '{12'h100, 12'hFFF, 12'hFFF, 12'h800, 12'h7FF};
        logic [7:0]  tb[5] = '{8'h10, 8'hFF, 8'hFF, 8'h80, 8'h80};
        logic [19:0] te[5] = '{20'h01000, 20'hFEF01, 20'h00001, 20'h40000, 20'hC0080};
        logic [19:0] ans;
        int          lat;
        bit          bok;
        bit          dn;
        for (int i = 0; i < 5; i++) begin
            run_op(ts[i], ta[i], tb[i], ans, lat, bok, dn);
            n_cmp++; if (ans !== te[i]) begin n_err++; $display("FAIL directed_%0d answer got %h want %h", i, ans, te[i]); end
            n_cmp++; if (lat != 5) begin n_err++; $display("FAIL directed_%0d latency got %0d want 5", i, lat); end
            n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL directed_%0d busy got %b want 1", i, bok); end
            n_cmp++; if (dn !== 1'b0) begin n_err++; $display("FAIL directed_%0d done_width got %b want 0", i, dn); end
            last_exp = te[i];
        end
    endtask

    task automatic test_start_while_busy();
        int          ndone;
        logic [19:0] ans;
        logic [19:0] exp;
        exp = ref1(1'b0, 12'h123, 8'h45);
        sm = 0; mpd = 12'h123; mpr = 8'h45; start = 1'b1;
        tick();
        start = 1'b0; mpd = 12'hFFF; mpr = 8'hFF; sm = 1'b1;
        tick();
        start = 1'b1; sm = 1'b1; mpd = 12'hABC; mpr = 8'h99;
        tick();
        start = 1'b0;
        ndone = 0;
        ans = 'x;
        for (int c = 0; c < 12; c++) begin
            mpd = 12'($urandom); mpr = 8'($urandom); sm = 1'($urandom);
            tick();
            if (done) begin ndone++; ans = answer; end
        end
        n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL busy_start_done_count got %0d want 1", ndone); end
        n_cmp++; if (ans !== exp) begin n_err++; $display("FAIL busy_start_answer got %h want %h", ans, exp); end
        last_exp = exp;
    endtask

    task automatic test_back_to_back();
        bit          bs[3] = '{1'b0, 1'b1, 1'b0};
        logic [11:0] ba[3] = '{12'h005, 12'hFF9, 12'h000};
        logic [7:0]  bb[3] = '{8'h03, 8'h09, 8'hAB};
        logic [19:0] be[3] = '{20'h0000F, 20'hFFFC1, 20'h00000};
        logic [19:0] held;
        int          ndone;
        int          last_t;
        held = last_exp;
        ndone = 0;
        last_t = 0;
        sm = bs[0]; mpd = ba[0]; mpr = bb[0]; start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            tick();
            if (done) begin
                if (ndone >= 3) begin
                    n_cmp++; n_err++; $display("FAIL b2b_extra_done got %0d pulses want 3", ndone + 1);
                end else begin
                    n_cmp++; if (answer !== be[ndone]) begin n_err++; $display("FAIL b2b_answer_%0d got %h want %h", ndone, answer, be[ndone]); end
                    n_cmp++; if (c - last_t != 6) begin n_err++; $display("FAIL b2b_interval_%0d got %0d want 6", ndone, c - last_t); end
                    held = be[ndone];
                end
                last_t = c;
                ndone++;
                if (ndone < 3) begin
                    sm = bs[ndone]; mpd = ba[ndone]; mpr = bb[ndone];
                end else begin
                    start = 1'b0;
                end
            end else begin
                n_cmp++; if (answer !== held) begin n_err++; $display("FAIL b2b_hold got %h want %h", answer, held); end
            end
        end
        n_cmp++; if (ndone != 3) begin n_err++; $display("FAIL b2b_done_count got %0d want 3", ndone); end
        last_exp = 20'h00000;
    endtask

    task automatic test_reset_mid();
        logic [19:0] ans;
        int          lat;
        bit          bok;
        bit          dn;
        int          ndone;
        run_op(1'b1, 12'h7FF, 8'h80, ans, lat, bok, dn);
        n_cmp++; if (ans !== 20'hC0080) begin n_err++; $display("FAIL rstmid_pre got %h want C0080", ans); end
        sm = 0; mpd = 12'h0AB; mpr = 8'hCD; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (answer !== 20'h0) begin n_err++; $display("FAIL rstmid_answer got %h want 00000", answer); end
        n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL rstmid_done got %b want 0", done); end
        tick();
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) ndone++;
        end
        n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL rstmid_stray_done got %0d want 0", ndone); end
        n_cmp++; if (answer !== 20'h0) begin n_err++; $display("FAIL rstmid_answer_after got %h want 00000", answer); end
        run_op(1'b0, 12'h0AB, 8'hCD, ans, lat, bok, dn);
        n_cmp++; if (ans !== ref1(1'b0, 12'h0AB, 8'hCD)) begin n_err++; $display("FAIL rstmid_next got %h want %h", ans, ref1(1'b0, 12'h0AB, 8'hCD)); end
        n_cmp++; if (lat != 5) begin n_err++; $display("FAIL rstmid_next_latency got %0d want 5", lat); end
    endtask

    task automatic test_random();
        logic [11:0] a1;
        logic [7:0]  b1;
        logic [15:0] a2;
        logic [6:0]  b2;
        logic [15:0] v;
        bit          s1;
        bit          s2;
        bit          got1;
        bit          got2;
        logic [19:0] r1;
        logic [22:0] r2;
        int          l1;
        int          l2;
        for (int n = 0; n < 10000; n++) begin
            v = pick(12); a1 = v[11:0];
            v = pick(8);  b1 = v[7:0];
            v = pick(16); a2 = v;
            v = pick(7);  b2 = v[6:0];
            s1 = 1'($urandom);
            s2 = 1'($urandom);
            sm = s1; mpd = a1; mpr = b1; start = 1'b1;
            sm2 = s2; mpd2 = a2; mpr2 = b2; start2 = 1'b1;
            tick();
            start = 1'b0;
            start2 = 1'b0;
            got1 = 0; got2 = 0; l1 = 0; l2 = 0; r1 = 'x; r2 = 'x;
            for (int c = 1; c <= 12; c++) begin
                tick();
                if (done && !got1)  begin got1 = 1; l1 = c; r1 = answer; end
                if (done2 && !got2) begin got2 = 1; l2 = c; r2 = answer2; end
                if (got1 && got2) break;
            end
            n_cmp++; if (r1 !== ref1(s1, a1, b1)) begin n_err++; $display("FAIL rand12x8 s=%0d %h*%h got %h want %h", s1, a1, b1, r1, ref1(s1, a1, b1)); end
            n_cmp++; if (l1 != 5) begin n_err++; $display("FAIL rand12x8_latency got %0d want 5", l1); end
            n_cmp++; if (r2 !== ref2(s2, a2, b2)) begin n_err++; $display("FAIL rand16x7 s=%0d %h*%h got %h want %h", s2, a2, b2, r2, ref2(s2, a2, b2)); end
            n_cmp++; if (l2 != 4) begin n_err++; $display("FAIL rand16x7_latency got %0d want 4", l2); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        last_exp = '0;
        test_reset();
        test_directed();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
